// File: rtl/prienc_pkg.sv
// Shared definitions for the pending-event priority arbiter family.
package prienc_pkg;

  localparam int PRI_FIXED = 0;
  localparam int PRI_RR    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } prienc_state_e;

endpackage

// File: rtl/prienc_n.sv
// N-input priority encoder: first set bit searching downward from start_i,
// wrapping from 0 to N-1. Generalises the legacy 4-to-2 encoder.
module prienc_n #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int W = $clog2(N);

  always_comb begin
    int unsigned p;
    any_o = 1'b0;
    idx_o = '0;
    p     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Position k steps below start, modulo N; keeps idx within 0..N-1.
      p = (32'(start_i) + N - k) % N;
      if (!any_o && vec_i[p]) begin
        any_o = 1'b1;
        idx_o = W'(p);
      end
    end
  end

endmodule

// File: rtl/prienc_arb.sv
// Registered priority arbiter: sticky pending bits, per-line mask, fixed or
// round-robin selection, valid/ack handshake and overrun pulse.
module prienc_arb
  import prienc_pkg::*;
#(
  parameter int N  = 8,
  parameter int RR = PRI_FIXED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx,
  input  logic                 ack,
  output logic [N-1:0]         pend,
  output logic                 ovf
);

  localparam int W = $clog2(N);

  prienc_state_e state_q, state_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [W-1:0]  idx_q, idx_d;
  logic          ovf_q, ovf_d;

  logic          grant;
  logic [N-1:0]  clr;
  logic [N-1:0]  elig;
  logic [W-1:0]  start;
  logic          any;
  logic [W-1:0]  win;

  // Set wins over clear: a strobe on the line being acked keeps it pending.
  always_comb begin
    grant  = (state_q == ST_HOLD) && ack;
    clr    = grant ? (N'(1) << idx_q) : '0;
    pend_d = req | (pend_q & ~clr);
    ovf_d  = |(req & pend_q & ~clr);
    elig   = pend_q & ~mask;
    start  = (RR == PRI_RR) ? ptr_q : W'(N - 1);
  end

  prienc_n #(.N(N)) u_enc (
    .vec_i   (elig),
    .start_i (start),
    .any_o   (any),
    .idx_o   (win)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          idx_d   = win;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ack) begin
          state_d = ST_IDLE;
          ptr_d   = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ptr_q   <= W'(N - 1);
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid = (state_q == ST_HOLD);
  assign idx   = idx_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_prienc_arb.sv
// Scoreboard bench: three arbiter instances (fixed N=8, RR N=8, RR N=5).
module tb_prienc_arb;
  import prienc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_v [2];
  logic [7:0] mask_v[2];
  logic [7:0] pend_v[2];
  logic [4:0] req_c, mask_c, pend_c;
  logic       valid_v[3];
  logic       ack_v  [3];
  logic       ovf_v  [3];
  logic [2:0] idx_v  [3];

  int checks = 0;
  int fails  = 0;
  int q[3][$];

  always #5 clk = ~clk;

  prienc_arb #(.N(8), .RR(PRI_FIXED)) u_fix (
    .clk(clk), .rst(rst), .req(req_v[0]), .mask(mask_v[0]), .valid(valid_v[0]),
    .idx(idx_v[0]), .ack(ack_v[0]), .pend(pend_v[0]), .ovf(ovf_v[0]));

  prienc_arb #(.N(8), .RR(PRI_RR)) u_rr8 (
    .clk(clk), .rst(rst), .req(req_v[1]), .mask(mask_v[1]), .valid(valid_v[1]),
    .idx(idx_v[1]), .ack(ack_v[1]), .pend(pend_v[1]), .ovf(ovf_v[1]));

  prienc_arb #(.N(5), .RR(PRI_RR)) u_rr5 (
    .clk(clk), .rst(rst), .req(req_c), .mask(mask_c), .valid(valid_v[2]),
    .idx(idx_v[2]), .ack(ack_v[2]), .pend(pend_c), .ovf(ovf_v[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_ack(input int d);
    int n;
    n = 0;
    while (valid_v[d] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk($sformatf("grant_wait_dut%0d", d), valid_v[d], 1);
    ack_v[d] = 1'b1;
    step();
    ack_v[d] = 1'b0;
    chk($sformatf("valid_drop_dut%0d", d), valid_v[d], 0);
  endtask

  // Monitor: each rising valid pops the next expected index.
  logic       vprev[3] = '{1'b0, 1'b0, 1'b0};
  logic [2:0] held [3];
  always @(negedge clk) begin
    int expv;
    for (int d = 0; d < 3; d++) begin
      if (valid_v[d] === 1'b1 && !vprev[d]) begin
        if (q[d].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_grant dut%0d: got idx %0d expected no grant", d, idx_v[d]);
        end else begin
          expv = q[d].pop_front();
          chk($sformatf("grant_idx_dut%0d", d), idx_v[d], expv);
        end
        held[d] = idx_v[d];
        if (d == 2) chk("idx_range_n5", idx_v[2] <= 3'd4, 1);
      end else if (valid_v[d] === 1'b1 && vprev[d]) begin
        chk($sformatf("idx_stable_dut%0d", d), idx_v[d], held[d]);
      end
      vprev[d] = (valid_v[d] === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) ack_v[d] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_v[d]  = '0;
      mask_v[d] = '0;
    end
    req_c  = '0;
    mask_c = '0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", valid_v[d], 0);
      chk("rst_idx", idx_v[d], 0);
      chk("rst_ovf", ovf_v[d], 0);
    end
    chk("rst_pend0", pend_v[0], 0);
    chk("rst_pend1", pend_v[1], 0);
    chk("rst_pend2", pend_c, 0);

    // Reset while holding a grant for line 5
    q[0].push_back(5);
    req_v[0] = 8'h20;
    step();
    req_v[0] = '0;
    step();
    chk("hold_valid", valid_v[0], 1);
    chk("hold_idx", idx_v[0], 5);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", valid_v[0], 0);
    chk("midrst_idx", idx_v[0], 0);
    chk("midrst_pend", pend_v[0], 0);
    chk("midrst_ovf", ovf_v[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step();
    chk("no_grant_after_rst", valid_v[0], 0);

    // Fixed priority: 0000_1010 -> 3 then 1
    q[0].push_back(3);
    q[0].push_back(1);
    req_v[0] = 8'h0A;
    step();
    req_v[0] = '0;
    chk("fix_pend_set", pend_v[0], 8'h0A);
    chk("fix_not_yet_valid", valid_v[0], 0);
    step();
    chk("fix_valid_e1", valid_v[0], 1);
    grant_ack(0);
    chk("fix_pend_after_ack", pend_v[0], 8'h02);
    grant_ack(0);
    chk("fix_pend_empty", pend_v[0], 0);
    repeat (3) step();
    chk("fix_idle", valid_v[0], 0);

    // Mask: line 7 masked -> 2 first; unmask during hold does not revoke
    q[0].push_back(2);
    q[0].push_back(7);
    mask_v[0] = 8'h80;
    req_v[0]  = 8'h84;
    step();
    req_v[0] = '0;
    step();
    chk("mask_idx", idx_v[0], 2);
    mask_v[0] = '0;
    repeat (2) step();
    chk("mask_hold_valid", valid_v[0], 1);
    chk("mask_hold_idx", idx_v[0], 2);
    grant_ack(0);
    grant_ack(0);
    chk("mask_pend_empty", pend_v[0], 0);

    // Fixed vs RR with lines 7,6 re-strobed on the first three acks
    q[0].push_back(7); q[0].push_back(7); q[0].push_back(7); q[0].push_back(7); q[0].push_back(6);
    q[1].push_back(7); q[1].push_back(6); q[1].push_back(7); q[1].push_back(6); q[1].push_back(7);
    req_v[0] = 8'hC0;
    req_v[1] = 8'hC0;
    step();
    req_v[0] = '0;
    req_v[1] = '0;
    for (int i = 0; i < 5; i++) begin
      int n;
      n = 0;
      while (valid_v[0] !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      chk("cmp_valid_fix", valid_v[0], 1);
      chk("cmp_valid_rr", valid_v[1], 1);
      ack_v[0] = 1'b1;
      ack_v[1] = 1'b1;
      if (i < 3) begin
        req_v[0] = 8'hC0;
        req_v[1] = 8'hC0;
      end
      step();
      ack_v[0] = 1'b0;
      ack_v[1] = 1'b0;
      req_v[0] = '0;
      req_v[1] = '0;
    end
    chk("cmp_pend_fix", pend_v[0], 0);
    chk("cmp_pend_rr", pend_v[1], 0);
    step();

    // Overrun: second strobe on a pending line, then strobe during its ack
    q[0].push_back(4);
    req_v[0] = 8'h10;
    step();
    req_v[0] = '0;
    chk("ovf_first_strobe", ovf_v[0], 0);
    step();
    step();
    req_v[0] = 8'h10;
    step();
    req_v[0] = '0;
    chk("ovf_pulse", ovf_v[0], 1);
    chk("ovf_pend", pend_v[0], 8'h10);
    step();
    chk("ovf_one_cycle", ovf_v[0], 0);
    chk("ovf_hold_idx", idx_v[0], 4);
    ack_v[0] = 1'b1;
    req_v[0] = 8'h10;
    step();
    ack_v[0] = 1'b0;
    req_v[0] = '0;
    chk("setwins_pend", pend_v[0], 8'h10);
    chk("setwins_ovf", ovf_v[0], 0);
    chk("setwins_valid", valid_v[0], 0);
    q[0].push_back(4);
    grant_ack(0);
    chk("setwins_pend_empty", pend_v[0], 0);

    // N=5 round-robin: 4,3,2,1,0 then wrap back to 4
    q[2].push_back(4); q[2].push_back(3); q[2].push_back(2); q[2].push_back(1); q[2].push_back(0);
    req_c = 5'h1F;
    step();
    req_c = '0;
    for (int i = 0; i < 5; i++) grant_ack(2);
    chk("n5_pend_empty", pend_c, 0);
    q[2].push_back(4);
    req_c = 5'h10;
    step();
    req_c = '0;
    grant_ack(2);
    chk("n5_wrap_pend", pend_c, 0);

    repeat (4) step();
    for (int d = 0; d < 3; d++) chk($sformatf("queue_empty_dut%0d", d), q[d].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
